// File: rtl/mxv_demux_sched.sv
// -----------------------------------------------------------------------------
// mxv_demux_sched
//
// Sequencer in front of the 1-to-4 byte demultiplexer of the matrix-vector
// datapath. It takes a valid/ready byte stream and, for every accepted beat,
// produces one cycle later a registered data byte, the demux selector, a
// one-hot lane write strobe and the element index inside that lane. One job
// fills all four lanes with ELEMS_PER_LANE bytes each and ends with a
// single-cycle done pulse that lines up with the strobe of the final write.
//
// Build option:
//   MXV_DEMUX_SCHED_INTERLEAVE_EN  defined   -> interleaved fill order: the
//                                              lane advances on every beat
//                                              and the element index advances
//                                              when the lane wraps 3 -> 0.
//                                  undefined -> block fill order: each lane
//                                              receives all of its elements
//                                              before the next lane starts.
//   The port list is identical in both builds.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   start_i      in   begin a job (only looked at while idle)
//   in_data_i    in   input element (DATA_W)
//   in_valid_i   in   in_data_i is valid
//   in_ready_o   out  beat is accepted this cycle when in_valid_i is high
//   sel_o        out  demux selector, aligned with lane_we_o
//   out_data_o   out  registered element to the demux data input (DATA_W)
//   lane_we_o    out  one-hot lane write strobe, bit k = lane k
//   lane_idx_o   out  element index within the lane (IDX_W)
//   busy_o       out  job in progress
//   done_o       out  one-cycle pulse, job complete
// -----------------------------------------------------------------------------
module mxv_demux_sched #(
    parameter int DATA_W         = 8,
    parameter int ELEMS_PER_LANE = 4,
    parameter int IDX_W          = (ELEMS_PER_LANE > 1) ? $clog2(ELEMS_PER_LANE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [1:0]        sel_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [3:0]        lane_we_o,
    output logic [IDX_W-1:0]  lane_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] ELEM_LAST = IDX_W'(ELEMS_PER_LANE - 1);
    localparam logic [IDX_W-1:0] ELEM_ONE  = IDX_W'(1);
    localparam logic [1:0]       LANE_LAST = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [IDX_W-1:0]  elem_q, elem_d;

    logic [1:0]        sel_q;
    logic [DATA_W-1:0] out_data_q;
    logic [3:0]        lane_we_q, lane_we_d;
    logic [IDX_W-1:0]  lane_idx_q;

    logic              accept;
    logic              last_beat;
    logic [3:0]        lane_dec;

    // A beat is taken only while running; there is no back-pressure in RUN.
    assign in_ready_o = (state_q == ST_RUN);
    assign accept     = in_ready_o && in_valid_i;
    assign last_beat  = accept && (lane_q == LANE_LAST) && (elem_q == ELEM_LAST);

    // One-hot decode of the current lane counter.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_dec
            assign lane_dec[gi] = (lane_q == 2'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        elem_d  = elem_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    lane_d  = 2'd0;
                    elem_d  = '0;
                end
            end

            ST_RUN: begin
                if (last_beat) begin
                    // Counters are left at zero so the next job starts clean.
                    state_d = ST_DONE;
                    lane_d  = 2'd0;
                    elem_d  = '0;
                end else if (accept) begin
`ifdef MXV_DEMUX_SCHED_INTERLEAVE_EN
                    // Round-robin over lanes; element index steps on lane wrap.
                    lane_d = lane_q + 2'd1;
                    if (lane_q == LANE_LAST) begin
                        elem_d = elem_q + ELEM_ONE;
                    end
`else
                    // Fill one lane completely before moving to the next.
                    if (elem_q == ELEM_LAST) begin
                        elem_d = '0;
                        lane_d = lane_q + 2'd1;
                    end else begin
                        elem_d = elem_q + ELEM_ONE;
                    end
`endif
                end
            end

            ST_DONE: begin
                // Start requests seen here are dropped, not queued.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                lane_d  = 2'd0;
                elem_d  = '0;
            end
        endcase
    end

    // Strobe is only ever high for the single cycle after an accept.
    assign lane_we_d = accept ? lane_dec : 4'b0000;

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lane_q  <= 2'd0;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            elem_q  <= elem_d;
        end
    end

    // Output register: selector, data and index are captured from the same
    // accepted beat so the downstream demux sees them aligned with the strobe.
    // Without an accept they keep their last values and only the strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= 2'd0;
            out_data_q <= '0;
            lane_we_q  <= 4'b0000;
            lane_idx_q <= '0;
        end else begin
            lane_we_q <= lane_we_d;
            if (accept) begin
                sel_q      <= lane_q;
                out_data_q <= in_data_i;
                lane_idx_q <= elem_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sel_o      = sel_q;
    assign out_data_o = out_data_q;
    assign lane_we_o  = lane_we_q;
    assign lane_idx_o = lane_idx_q;
    assign busy_o     = (state_q == ST_RUN);
    // DONE lasts exactly one cycle and is entered on the same edge that
    // registers the final write, so the pulse coincides with that strobe.
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_mxv_demux_sched.sv
module tb_mxv_demux_sched;

    localparam int E      = 4;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 2;
    localparam int BEATS  = 4 * E;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [1:0]        sel_o;
    logic [DATA_W-1:0] out_data_o;
    logic [3:0]        lane_we_o;
    logic [IDX_W-1:0]  lane_idx_o;
    logic              busy_o;
    logic              done_o;

    int checks = 0;
    int errors = 0;
    int done_count;

    mxv_demux_sched #(
        .DATA_W(DATA_W),
        .ELEMS_PER_LANE(E)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .in_data_i(in_data_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .sel_o(sel_o),
        .out_data_o(out_data_o),
        .lane_we_o(lane_we_o),
        .lane_idx_o(lane_idx_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected lane / index of beat number i.
    function automatic int exp_lane(input int i);
`ifdef MXV_DEMUX_SCHED_INTERLEAVE_EN
        return i % 4;
`else
        return i / E;
`endif
    endfunction

    function automatic int exp_idx(input int i);
`ifdef MXV_DEMUX_SCHED_INTERLEAVE_EN
        return i / 4;
`else
        return i % E;
`endif
    endfunction

    // Drive one accepted beat and check the registered write one edge later.
    task automatic beat(input int i, input logic [7:0] d);
        in_valid_i = 1'b1;
        in_data_i  = d;
        chk("in_ready_run", 32'(in_ready_o), 32'd1);
        tick();
        if (done_o) done_count++;
        $display("beat %0d data=0x%02h sel=%0d we=%b idx=%0d done=%0b",
                 i, out_data_o, sel_o, lane_we_o, lane_idx_o, done_o);
        chk("out_data", 32'(out_data_o), 32'(d));
        chk("sel", 32'(sel_o), 32'(exp_lane(i)));
        chk("lane_we", 32'(lane_we_o), 32'(1) << exp_lane(i));
        chk("lane_idx", 32'(lane_idx_o), 32'(exp_idx(i)));
        chk("done", 32'(done_o), (i == BEATS - 1) ? 32'd1 : 32'd0);
        in_valid_i = 1'b0;
    endtask

    task automatic start_job();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        in_data_i  = '0;
        in_valid_i = 1'b0;
        done_count = 0;

        // ---------------- reset state ----------------
        tick();
        tick();
        $display("reset: sel=%0d data=0x%02h we=%b idx=%0d busy=%0b done=%0b rdy=%0b",
                 sel_o, out_data_o, lane_we_o, lane_idx_o, busy_o, done_o, in_ready_o);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_out_data", 32'(out_data_o), 32'd0);
        chk("rst_lane_we", 32'(lane_we_o), 32'd0);
        chk("rst_lane_idx", 32'(lane_idx_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- job 1: back-to-back beats ----------------
        start_job();
        done_count = 0;
        for (int i = 0; i < BEATS; i++) beat(i, 8'(8'h10 + i));
        chk("job1_ready_in_done", 32'(in_ready_o), 32'd0);
        chk("job1_busy_in_done", 32'(busy_o), 32'd0);
        tick();
        chk("job1_done_cleared", 32'(done_o), 32'd0);
        chk("job1_we_cleared", 32'(lane_we_o), 32'd0);
        chk("job1_ready_idle", 32'(in_ready_o), 32'd0);
        chk("job1_done_count", 32'(done_count), 32'd1);

        // ---------------- job 2: in_valid every other cycle ----------------
        start_job();
        done_count = 0;
        begin
            int done_cycle;
            done_cycle = -1;
            for (int c = 0; c < 2 * BEATS - 1; c++) begin
                if (c % 2 == 0) begin
                    beat(c / 2, 8'(8'h10 + c / 2));
                    if (done_o) done_cycle = c + 1;
                end else begin
                    in_valid_i = 1'b0;
                    in_data_i  = 8'hEE;
                    tick();
                    $display("gap %0d data=0x%02h we=%b done=%0b", c, out_data_o, lane_we_o, done_o);
                    chk("gap_lane_we", 32'(lane_we_o), 32'd0);
                    chk("gap_out_hold", 32'(out_data_o), 32'(8'h10 + c / 2));
                    chk("gap_sel_hold", 32'(sel_o), 32'(exp_lane(c / 2)));
                    chk("gap_idx_hold", 32'(lane_idx_o), 32'(exp_idx(c / 2)));
                    chk("gap_done", 32'(done_o), 32'd0);
                end
            end
            chk("job2_done_cycle", 32'(done_cycle), 32'd31);
        end
        tick();
        chk("job2_done_count", 32'(done_count), 32'd1);

        // ---------------- valid in IDLE without start ----------------
        for (int k = 0; k < 5; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'hAA;
            chk("idle_ready", 32'(in_ready_o), 32'd0);
            tick();
            $display("idle %0d data=0x%02h we=%b busy=%0b", k, out_data_o, lane_we_o, busy_o);
            chk("idle_we", 32'(lane_we_o), 32'd0);
            chk("idle_out_hold", 32'(out_data_o), 32'h1F);
            chk("idle_busy", 32'(busy_o), 32'd0);
        end
        in_valid_i = 1'b0;

        // ---------------- async reset mid-job ----------------
        start_job();
        for (int i = 0; i < 6; i++) beat(i, 8'(8'h40 + i));
        #2;
        rst_n = 1'b0;
        #1;
        $display("midreset: sel=%0d data=0x%02h we=%b idx=%0d busy=%0b done=%0b",
                 sel_o, out_data_o, lane_we_o, lane_idx_o, busy_o, done_o);
        chk("arst_out_data", 32'(out_data_o), 32'd0);
        chk("arst_sel", 32'(sel_o), 32'd0);
        chk("arst_lane_idx", 32'(lane_idx_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_ready", 32'(in_ready_o), 32'd0);
        tick();
        chk("arst_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("arst_idle_busy", 32'(busy_o), 32'd0);
        chk("arst_idle_done", 32'(done_o), 32'd0);
        start_job();
        done_count = 0;
        for (int i = 0; i < BEATS; i++) beat(i, 8'(8'h50 + i));
        tick();
        chk("restart_done_count", 32'(done_count), 32'd1);

        // ---------------- start pulsed during RUN ----------------
        start_job();
        done_count = 0;
        for (int i = 0; i < BEATS; i++) begin
            start_i = (i == 3);
            beat(i, 8'(8'h60 + i));
        end
        start_i = 1'b0;
        tick();
        chk("rstart_idle", 32'(busy_o), 32'd0);
        tick();
        chk("rstart_not_queued", 32'(busy_o), 32'd0);
        chk("rstart_done_count", 32'(done_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mxv_demux_sched.md
Name: mxv_demux_sched

Overview:
- Sequencer that feeds a 1-to-4 byte demultiplexer in the matrix-vector datapath.
- Accepts a valid/ready byte stream and generates the demux select, a registered data byte, a one-hot lane write strobe and an element index for each accepted beat.
- Fills 4 lanes (matrix rows / PE input buffers) with ELEMS_PER_LANE bytes each per job, then signals done.
- Sits between the input stream source and the demux/lane buffers; the downstream demux is purely combinational on its outputs.

Parameters:
- DATA_W, 8, width of a data element (uint8_t in mxv_pkg).
- ELEMS_PER_LANE, 4, bytes written to each lane per job; legal range 1..256.
- IDX_W, $clog2(ELEMS_PER_LANE) (min 1), width of the element index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- in_data  in  DATA_W  input element.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- sel  out  2  demux selector, aligned with lane_we.
- out_data  out  DATA_W  registered element to the demux data input.
- lane_we  out  4  one-hot write strobe; bit k = lane k.
- lane_idx  out  IDX_W  element index within lane, aligned with lane_we.
- busy  out  1  job in progress (RUN).
- done  out  1  one-cycle pulse, job complete.

Behaviour:
- Reset (rst=0, async): state=IDLE. sel=0, out_data=0, lane_we=0, lane_idx=0, busy=0, done=0, in_ready=0. Internal lane/elem counters are 0.
- A reset asserted mid-job aborts the job immediately. No done pulse is produced. After release the block waits for a new start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> RUN, with lane counter=0 and elem counter=0.
  - start=0 -> stay in IDLE.
- RUN:
  - in_ready=1 combinationally (no back-pressure in the base build); busy=1.
  - A beat is accepted when in_valid && in_ready.
  - On an accepted beat, the next edge sets:
    - out_data <= in_data
    - sel <= lane counter
    - lane_idx <= elem counter
    - lane_we <= 1<<lane counter, for exactly one cycle
  - Write latency is 1 cycle from acceptance.
  - With no accepted beat, lane_we=0 next cycle; sel, out_data and lane_idx hold their last values.
- Counter advance (block mode) on each accepted beat:
  - If elem counter == ELEMS_PER_LANE-1: elem=0 and lane counter increments.
  - Otherwise elem increments.
  - On the last beat (lane==3 and elem==ELEMS_PER_LANE-1): counters return to 0 and the FSM moves to DONE.
- DONE:
  - in_ready=0, busy=0.
  - done=1 for this single cycle, which coincides with lane_we of the final beat.
  - Then unconditionally -> IDLE.
- A job is always exactly 4*ELEMS_PER_LANE accepted beats. in_valid gaps stretch the job but do not change the count.
- start while in RUN or DONE is ignored and not queued.
- in_valid in IDLE or DONE is not accepted; data is not consumed.
- ELEMS_PER_LANE=1: the lane advances on every beat, and the job is 4 beats.
- Back-to-back jobs: start asserted in the cycle after DONE (IDLE) gives a minimum 2-cycle gap between the last accept of one job and the first accept of the next.

Optional Feature:
- Macro: MXV_DEMUX_SCHED_INTERLEAVE_EN.
- Defined (interleaved mode):
  - The lane counter advances on every accepted beat (0,1,2,3,0,...).
  - The elem counter increments when the lane wraps 3->0.
  - The job ends after the beat with lane==3 and elem==ELEMS_PER_LANE-1.
  - The total beat count is unchanged.
- Undefined: block mode exactly as described in Behaviour. Ports are identical in both builds.

Test Plan (ELEMS_PER_LANE=4):
- Reset, then start=1 for 1 cycle, then 16 back-to-back beats with in_data=0x10..0x1F:
  - lane_we=0001 for 0x10-0x13 (lane_idx 0..3), 0010 for 0x14-0x17, 0100 for 0x18-0x1B, 1000 for 0x1C-0x1F.
  - done pulses once, coinciding with the 0x1F write.
  - in_ready=0 afterwards.
- Same stream with in_valid deasserted every other cycle -> identical write sequence, lane_we=0 in the gap cycles, and done occurs after 31 accept-window cycles.
- in_valid=1 with data 0xAA while in IDLE without start for 5 cycles -> in_ready=0, lane_we=0, no consumption.
- Drive rst=0 after 6 beats, then restart -> outputs return to 0 asynchronously with no done pulse. The new job starts at lane 0, lane_idx 0.
- Pulse start again during RUN at beat 3 -> ignored; the job still completes after exactly 16 beats with a single done.
- With MXV_DEMUX_SCHED_INTERLEAVE_EN, 16 beats 0x00..0x0F:
  - sel sequence is 0,1,2,3 repeated.
  - lane_idx is 0 for 0x00-0x03 and 3 for 0x0C-0x0F.
  - done coincides with 0x0F.
